// File: rtl/sll_multicycle.sv
// Iterative 32-bit logical left shifter: one barrel stage per clock (16, 8, 4, 2, 1).
// Operands are accepted via start/busy/done; data_out updates only on completion.
module sll_multicycle (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] data_out_q, data_out_d;
    logic [4:0]  sh_q, sh_d;
    logic [2:0]  stg_q, stg_d;
    logic        done_q, done_d;
    logic [31:0] acc_step;

    // Stage stg handles shift-amount bit 4-stg, largest stride first.
    always_comb begin
        acc_step = acc_q;
        case (stg_q)
            3'd0: if (sh_q[4]) acc_step = acc_q << 16;
            3'd1: if (sh_q[3]) acc_step = acc_q << 8;
            3'd2: if (sh_q[2]) acc_step = acc_q << 4;
            3'd3: if (sh_q[1]) acc_step = acc_q << 2;
            3'd4: if (sh_q[0]) acc_step = acc_q << 1;
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        stg_d      = stg_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = data_in;
                    sh_d    = shamt;
                    stg_d   = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                stg_d = stg_q + 3'd1;
                if (stg_q == 3'd4) begin
                    data_out_d = acc_step;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= 32'h0;
            sh_q       <= 5'h0;
            stg_q      <= 3'h0;
            data_out_q <= 32'h0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            stg_q      <= stg_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_sll_multicycle.sv
// Self-checking bench for sll_multicycle: directed cases plus random operands
// compared against a plain-arithmetic shift model, with cycle-exact handshake checks.
module tb_sll_multicycle;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [4:0]  shamt = 5'h0;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] prev_out = 32'h0;

    sll_multicycle dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .shamt    (shamt),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_sll(input logic [31:0] d, input logic [4:0] s);
        logic [63:0] wide;
        wide = {32'h0, d} * (64'd1 << s);
        return wide[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Must be called at a negedge. hold_start keeps start high through the op;
    // junk_d is driven on data_in while busy to prove operands are latched.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                          input bit hold_start, input logic [31:0] junk_d);
        logic [31:0] exp;
        exp     = ref_sll(d, s);
        start   = 1'b1;
        data_in = d;
        shamt   = s;
        @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (!hold_start) start = 1'b0;
            data_in = junk_d;
            shamt   = 5'($urandom);
            check($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
            check($sformatf("done_low_c%0d", i), 32'(done), 32'd0);
            check($sformatf("out_hold_c%0d", i), data_out, prev_out);
        end
        @(negedge clock);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_drop", 32'(busy), 32'd0);
        check($sformatf("result_%h_sh%0d", d, s), data_out, exp);
        prev_out = exp;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", data_out, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_op(32'h00000001, 5'd31, 1'b0, $urandom);
        @(negedge clock);
        check("done_one_cycle", 32'(done), 32'd0);

        run_op(32'hFFFFFFFF, 5'd4, 1'b0, $urandom);
        run_op(32'h12345678, 5'd0, 1'b0, $urandom);

        // Back-to-back with start held high
        run_op(32'h0000000F, 5'd8, 1'b1, 32'h0000000F);
        run_op(32'h0000000F, 5'd1, 1'b1, 32'h0000000F);
        run_op(32'h0000000F, 5'd8, 1'b1, 32'h0000000F);
        start = 1'b0;

        // Start re-asserted during SHIFT is ignored
        run_op(32'h00000003, 5'd2, 1'b1, 32'hDEADBEEF);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("no_extra_done_%0d", i), 32'(done), 32'd0);
            check($sformatf("no_extra_busy_%0d", i), 32'(busy), 32'd0);
        end
        check("restart_ignored_out", data_out, 32'h0000000C);

        // Operands changed right after acceptance
        run_op(32'h0000AAAA, 5'd16, 1'b0, 32'h0);

        // Asynchronous reset mid-operation (between E2 and E3)
        start   = 1'b1;
        data_in = 32'h00FF00FF;
        shamt   = 5'd3;
        @(posedge clock);
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_out", data_out, 32'h0);
        prev_out = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check($sformatf("arst_no_done_%0d", i), 32'(done), 32'd0);
        end
        run_op(32'h00FF00FF, 5'd3, 1'b0, $urandom);

        // Random operands against the model
        for (int n = 0; n < 20; n++) begin
            run_op($urandom, 5'($urandom), n[0], $urandom);
            start = 1'b0;
            if (n % 3 == 0) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sll_multicycle.md
# sll_multicycle

Iterative 32-bit logical left shifter for the processor's ALU path. It is the left-shift counterpart of the combinational arithmetic-right-shift stages. It applies one barrel stage per clock: 16, then 8, 4, 2 and 1. Operands are accepted with a start/busy/done handshake, so the execute stage can stall on `busy` and capture the result on `done`.

## Interface
- No parameters; width is fixed at 32 bits and the shift amount at 5 bits.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous reset, active-high.
- `start`  in  1  request; sampled on a rising edge while idle.
- `data_in`  in  32  operand to shift.
- `shamt`  in  5  shift amount, 0–31.
- `data_out`  out  32  result register; holds its value until the next accepted start.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when `data_out` becomes valid.

## Operation
- States:
  - IDLE: `busy`=0.
  - SHIFT: `busy`=1. A 3-bit stage counter `stg` runs 0..4.
- IDLE, `start`=1 at an edge:
  - Latch `data_in` into the working register `acc`.
  - Latch `shamt` into `sh_q`.
  - Set `stg`=0 and go to SHIFT.
  - `done` is 0 in the following cycle.
- IDLE, `start`=0: remain in IDLE. `data_out` and `acc` hold.
- SHIFT, each edge:
  - Let k = 4 − `stg`.
  - If `sh_q[k]`=1, `acc` ← `acc` << 2^k, zero-filling from bit 0. Bits shifted out of bit 31 are discarded.
  - Otherwise `acc` holds.
  - `stg` increments.
- SHIFT, at the edge where `stg`=4 (the 1-bit stage):
  - Write the final value to `data_out`.
  - Drive `done`=1 and go to IDLE.
- `done` is a registered output. It is high for exactly the one cycle after the final stage edge.
- `start` asserted while in SHIFT is ignored. It is not queued, and the in-flight operands are unaffected.
- `data_in` and `shamt` are don't-care except at the accepting edge. Later changes must not alter the result.
- Arithmetic rule: `data_out` = (`data_in` << `shamt`) mod 2^32, logical with zero fill. `shamt`=0 yields `data_in` unchanged, with the same latency as any other amount.
- The result is never sign-extended and no overflow flag is produced.

## Timing
- Reset asserted, at any time and independent of `clock`:
  - `busy`=0, `done`=0, `data_out`=32'h0.
  - `acc`=0, `sh_q`=0, `stg`=0, state=IDLE.
- Reset during SHIFT aborts the operation. No `done` pulse is produced for it.
- After reset is released, the first rising edge with `start`=1 is accepted.
- Latency, with the start edge as E0:
  - Stage edges are E1..E5.
  - `done`=1 and the result is valid in the cycle after E5.
  - `busy` is high in the cycles following E0 through E4. It drops together with the rise of `done`.
- Throughput: the block is IDLE in the `done` cycle. A `start` sampled at the edge that ends the `done` cycle is accepted, so back-to-back issue rate is one operation per 6 cycles.
- `data_out` changes only at the final stage edge and at reset. Mid-operation values of `acc` are never visible on `data_out`.
- `done` and `start` are independent signals. A new accept while `done`=1 is legal and does not extend the `done` pulse.

## Test plan
- Reset, then `data_in`=32'h00000001, `shamt`=31, `start` pulsed one cycle → `done` in the cycle after E5; `data_out`=32'h80000000; `busy` high for exactly 5 cycles.
- `data_in`=32'hFFFFFFFF with `shamt`=4 → `data_out`=32'hFFFFFFF0. Then `data_in`=32'h12345678 with `shamt`=0 → `data_out`=32'h12345678, still with 6-edge latency.
- Back-to-back: `start` held high continuously, `data_in`=32'h0000000F, `shamt` alternating 8 and 1 → results 32'h00000F00 and 32'h0000001E, with `done` pulses exactly 6 cycles apart.
- `start` re-asserted during SHIFT with `data_in`=32'hDEADBEEF → ignored; the in-flight op (32'h00000003, `shamt`=2) returns 32'h0000000C and no extra `done` follows.
- Operands changed at E1: `data_in`=32'h0000AAAA, `shamt`=16 accepted, then inputs changed to 32'h0 / 0 → `data_out`=32'hAAAA0000.
- Reset asserted asynchronously between E2 and E3 → `busy`, `done` and `data_out` go to 0 immediately, no `done` pulse follows, and the next start completes normally.
